// File: rtl/protected_register_file_if.sv
// Request/response bundle between the UART command parser (master) and the
// protected register file (slave).
interface protected_register_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              re;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              TX_start;
  logic              addr_err;
  logic              wp_err;
  logic              locked;
  logic [7:0]        err_cnt;

  modport master (
    output we, w_addr, w_data, re, r_addr,
    input  r_data, TX_start, addr_err, wp_err, locked, err_cnt
  );

  modport slave (
    input  we, w_addr, w_data, re, r_addr,
    output r_data, TX_start, addr_err, wp_err, locked, err_cnt
  );
endinterface

// File: rtl/protected_register_file.sv
// DEPTH x DATA_W register file with registered reads, address checking, a
// two-key write-protection lock at the top address and a saturating error counter.
module protected_register_file #(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 8,
  parameter int                DEPTH  = 64,
  parameter logic [DATA_W-1:0] KEY1   = DATA_W'(8'h5A),
  parameter logic [DATA_W-1:0] KEY2   = DATA_W'(8'hA5)
) (
  input  logic                      clk,
  input  logic                      reset,
  protected_register_file_if.slave  bus
);

  localparam int                NREG      = DEPTH - 1;
  localparam int                IDX_W     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_UNLOCKED  = 2'd0,
    S_LOCKED    = 2'd1,
    S_KEY1_SEEN = 2'd2
  } lock_state_t;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  lock_state_t       r_state;
  logic              r_locked;
  logic              r_key1_seen;
  logic [DATA_W-1:0] r_mem [NREG];
  logic [DATA_W-1:0] r_rdata_p1;
  logic              r_vld_p1;
  logic              r_addr_err_p1;
  logic              r_wp_err_p1;
  logic [7:0]        r_err_cnt_p1;

  logic              w_wr_valid, w_wr_lock, w_wr_inv, w_wr_blk, w_wr_do;
  logic              w_rd_valid, w_rd_lock, w_rd_inv;
  logic [IDX_W-1:0]  w_widx, w_ridx;
  logic [1:0]        w_err_inc;

  // Address decode uses one extra bit so DEPTH = 2^ADDR_W is representable.
  assign w_wr_valid = {1'b0, bus.w_addr} < DEPTH_EXT;
  assign w_wr_lock  = bus.w_addr == LOCK_ADDR;
  assign w_rd_valid = {1'b0, bus.r_addr} < DEPTH_EXT;
  assign w_rd_lock  = bus.r_addr == LOCK_ADDR;
  assign w_widx     = bus.w_addr[IDX_W-1:0];
  assign w_ridx     = bus.r_addr[IDX_W-1:0];

  assign w_wr_inv   = bus.we & ~w_wr_valid;
  assign w_rd_inv   = bus.re & ~w_rd_valid;
  assign w_wr_blk   = bus.we & w_wr_valid & ~w_wr_lock & (r_state != S_UNLOCKED);
  assign w_wr_do    = bus.we & w_wr_valid & ~w_wr_lock & (r_state == S_UNLOCKED);
  assign w_err_inc  = {1'b0, w_wr_inv} + {1'b0, w_rd_inv} + {1'b0, w_wr_blk};

  // Lock FSM: only cycles with a write request can move it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_UNLOCKED;
      r_locked    <= 1'b0;
      r_key1_seen <= 1'b0;
    end else if (bus.we) begin
      unique case (r_state)
        S_UNLOCKED: begin
          if (w_wr_lock) begin
            r_state  <= S_LOCKED;
            r_locked <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_wr_lock && bus.w_data == KEY1) begin
            r_state     <= S_KEY1_SEEN;
            r_key1_seen <= 1'b1;
          end
        end
        S_KEY1_SEEN: begin
          if (w_wr_lock && bus.w_data == KEY2) begin
            r_state     <= S_UNLOCKED;
            r_locked    <= 1'b0;
            r_key1_seen <= 1'b0;
          end else if (!(w_wr_lock && bus.w_data == KEY1)) begin
            r_state     <= S_LOCKED;
            r_key1_seen <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_LOCKED;
          r_locked    <= 1'b1;
          r_key1_seen <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wr_do) begin
      r_mem[w_widx] <= bus.w_data;
    end
  end

  // Response stage: read data and status pulses, one cycle after the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata_p1    <= '0;
      r_vld_p1      <= 1'b0;
      r_addr_err_p1 <= 1'b0;
      r_wp_err_p1   <= 1'b0;
      r_err_cnt_p1  <= '0;
    end else begin
      r_vld_p1      <= bus.re;
      r_addr_err_p1 <= w_wr_inv | w_rd_inv;
      r_wp_err_p1   <= w_wr_blk;
      r_err_cnt_p1  <= sat_add(r_err_cnt_p1, w_err_inc);
      if (bus.re) begin
        if (!w_rd_valid)    r_rdata_p1 <= '0;
        else if (w_rd_lock) r_rdata_p1 <= DATA_W'({r_key1_seen, r_locked});
        else                r_rdata_p1 <= r_mem[w_ridx];
      end
    end
  end

  assign bus.r_data   = r_rdata_p1;
  assign bus.TX_start = r_vld_p1;
  assign bus.addr_err = r_addr_err_p1;
  assign bus.wp_err   = r_wp_err_p1;
  assign bus.locked   = r_locked;
  assign bus.err_cnt  = r_err_cnt_p1;

endmodule

// File: tb/tb_protected_register_file.sv
// Directed bench for protected_register_file: read results go through a
// scoreboard queue; status outputs are checked every cycle.
module tb_protected_register_file;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  protected_register_file_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  protected_register_file #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(64), .KEY1(8'h5A), .KEY2(8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         checks  = 0;
  int         errors  = 0;
  int         exp_cnt = 0;
  logic [7:0] last_rd = 8'h00;
  logic [7:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request cycle: drive at negedge, check the response 1 ns after the edge.
  task automatic cyc(input bit we_i, input int wa, input int wd,
                     input bit re_i, input int ra, input logic [7:0] rexp,
                     input bit exp_wp, input bit exp_lk);
    bit         ae;
    int         inc;
    logic [7:0] d;
    @(negedge clk);
    bus.we     = we_i;
    bus.w_addr = 8'(wa);
    bus.w_data = 8'(wd);
    bus.re     = re_i;
    bus.r_addr = 8'(ra);
    if (re_i) sb_q.push_back(rexp);
    ae      = (we_i && wa >= 64) || (re_i && ra >= 64);
    inc     = int'(we_i && wa >= 64) + int'(re_i && ra >= 64) + int'(exp_wp);
    exp_cnt = (exp_cnt + inc > 255) ? 255 : exp_cnt + inc;
    @(posedge clk);
    #1;
    chk("tx_start", 32'(bus.TX_start), 32'(re_i));
    if (bus.TX_start === 1'b1) begin
      chk("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        d       = sb_q.pop_front();
        last_rd = d;
      end
    end
    chk("r_data",   32'(bus.r_data),   32'(last_rd));
    chk("addr_err", 32'(bus.addr_err), 32'(ae));
    chk("wp_err",   32'(bus.wp_err),   32'(exp_wp));
    chk("locked",   32'(bus.locked),   32'(exp_lk));
    chk("err_cnt",  32'(bus.err_cnt),  exp_cnt);
  endtask

  initial begin
    bus.we = 1'b0; bus.w_addr = '0; bus.w_data = '0;
    bus.re = 1'b0; bus.r_addr = '0;
    reset  = 1'b0;
    #12;
    chk("rst_r_data",   32'(bus.r_data),   0);
    chk("rst_tx",       32'(bus.TX_start), 0);
    chk("rst_addr_err", 32'(bus.addr_err), 0);
    chk("rst_wp_err",   32'(bus.wp_err),   0);
    chk("rst_locked",   32'(bus.locked),   0);
    chk("rst_err_cnt",  32'(bus.err_cnt),  0);
    @(negedge clk);
    reset = 1'b1;

    // basic write/read
    cyc(1, 5, 'hAB, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1, 5, 8'hAB, 0, 0);

    // out-of-range write then read
    cyc(1, 70, 'h55, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1, 70, 8'h00, 0, 0);

    // lock, blocked write, unlock, accepted write
    cyc(1, 3, 'h77, 0, 0, 8'h00, 0, 0);
    cyc(1, 63, 'h00, 0, 0, 8'h00, 0, 1);
    cyc(1, 3, 'h11, 0, 0, 8'h00, 1, 1);
    cyc(1, 63, 'h5A, 0, 0, 8'h00, 0, 1);
    cyc(0, 0, 0, 1, 63, 8'h03, 0, 1);
    cyc(1, 63, 'hA5, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1, 3, 8'h77, 0, 0);
    cyc(1, 3, 'h11, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1, 3, 8'h11, 0, 0);

    // broken key sequence via a data write
    cyc(1, 63, 'h00, 0, 0, 8'h00, 0, 1);
    cyc(1, 63, 'h5A, 0, 0, 8'h00, 0, 1);
    cyc(1, 4, 'h22, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 1, 63, 8'h01, 0, 1);
    cyc(0, 0, 0, 1, 4, 8'h00, 0, 1);
    // repeated KEY1 keeps KEY1_SEEN; unlock write with lock read sees old state
    cyc(1, 63, 'h5A, 0, 0, 8'h00, 0, 1);
    cyc(1, 63, 'h5A, 0, 0, 8'h00, 0, 1);
    cyc(1, 63, 'hA5, 1, 63, 8'h03, 0, 0);

    // invalid write also breaks the sequence, with addr_err but no wp_err
    cyc(1, 63, 'h00, 0, 0, 8'h00, 0, 1);
    cyc(1, 63, 'h5A, 0, 0, 8'h00, 0, 1);
    cyc(1, 70, 'h09, 0, 0, 8'h00, 0, 1);
    cyc(1, 63, 'hA5, 0, 0, 8'h00, 0, 1);
    cyc(0, 0, 0, 1, 63, 8'h01, 0, 1);
    cyc(1, 63, 'h5A, 0, 0, 8'h00, 0, 1);
    cyc(1, 63, 'h33, 0, 0, 8'h00, 0, 1);
    cyc(0, 0, 0, 1, 63, 8'h01, 0, 1);
    cyc(1, 63, 'h5A, 0, 0, 8'h00, 0, 1);
    cyc(1, 63, 'hA5, 0, 0, 8'h00, 0, 0);

    // simultaneous read and write to one address: read-before-write
    cyc(1, 7, 'h33, 0, 0, 8'h00, 0, 0);
    cyc(1, 7, 'h44, 1, 7, 8'h33, 0, 0);
    cyc(0, 0, 0, 1, 7, 8'h44, 0, 0);

    // error counter saturation
    for (int i = 0; i < 130; i++) cyc(1, 200, 1, 1, 200, 8'h00, 0, 0);
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'hFF);

    // asynchronous reset mid-cycle, with pending pulses and lock set
    cyc(1, 63, 'h00, 1, 200, 8'h00, 0, 1);
    bus.we = 1'b0; bus.re = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_r_data",   32'(bus.r_data),   0);
    chk("mid_rst_tx",       32'(bus.TX_start), 0);
    chk("mid_rst_addr_err", 32'(bus.addr_err), 0);
    chk("mid_rst_wp_err",   32'(bus.wp_err),   0);
    chk("mid_rst_locked",   32'(bus.locked),   0);
    chk("mid_rst_err_cnt",  32'(bus.err_cnt),  0);
    exp_cnt = 0;
    last_rd = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 1, 5, 8'h00, 0, 0);
    cyc(0, 0, 0, 0, 0, 8'h00, 0, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
